// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// A grant lasts until end-of-packet, the burst limit, or an idle timeout.
module fifo_wr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DW           = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8,
    localparam int GW          = $clog2(N_REQ)
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_last,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    input  logic                fifo_full,
    input  logic                fifo_overrun,
    output logic                fifo_wen,
    output logic [DW-1:0]       fifo_din,
    output logic [GW-1:0]       grant_id,
    output logic                busy,
    output logic                overrun_err,
    input  logic                err_clr
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
    localparam logic [7:0] TO_CNT = 8'(IDLE_TIMEOUT);
    localparam logic [GW:0] N_W   = (GW+1)'(N_REQ);
    localparam logic [GW-1:0] LAST_ID = GW'(N_REQ - 1);

    state_t        state_reg, state_next;
    logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GW-1:0] grant_id_reg, grant_id_next;
    logic [7:0]    burst_cnt_reg, burst_cnt_next;
    logic [7:0]    idle_cnt_reg, idle_cnt_next;
    logic          overrun_err_reg, overrun_err_next;
    logic [GW-1:0] pick;
    logic          release_grant;
    logic [DW-1:0] data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_port
            assign data_arr[gi]  = req_data[gi*DW +: DW];
            assign req_ready[gi] = (state_reg == GRANT) && (grant_id_reg == GW'(gi)) && !fifo_full;
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic          found;
        logic [GW:0]   sum;
        logic [GW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_reg} + (GW+1)'(k);
            if (sum >= N_W)
                sum = sum - N_W;
            idx = sum[GW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_id_next  = grant_id_reg;
        burst_cnt_next = burst_cnt_reg;
        idle_cnt_next  = idle_cnt_reg;
        release_grant  = 1'b0;
        fifo_wen       = 1'b0;
        fifo_din       = '0;
        busy           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_next  = pick;
                    burst_cnt_next = '0;
                    idle_cnt_next  = '0;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                busy     = 1'b1;
                fifo_wen = req_valid[grant_id_reg] & !fifo_full;
                fifo_din = data_arr[grant_id_reg];
                if (fifo_wen) begin
                    burst_cnt_next = burst_cnt_reg + 8'd1;
                    idle_cnt_next  = '0;
                    if (req_last[grant_id_reg] || (burst_cnt_reg + 8'd1 == MAX_B))
                        release_grant = 1'b1;
                end else if (req_valid[grant_id_reg]) begin
                    // Stalled by a full FIFO: the requester is not idle.
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 8'd1;
                    if (idle_cnt_reg + 8'd1 == TO_CNT)
                        release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_next  = IDLE;
                    rr_ptr_next = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        overrun_err_next = overrun_err_reg;
        if (fifo_overrun || (fifo_wen && fifo_full))
            overrun_err_next = 1'b1;
        else if (err_clr)
            overrun_err_next = 1'b0;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            burst_cnt_reg   <= '0;
            idle_cnt_reg    <= '0;
            overrun_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            grant_id_reg    <= grant_id_next;
            burst_cnt_reg   <= burst_cnt_next;
            idle_cnt_reg    <= idle_cnt_next;
            overrun_err_reg <= overrun_err_next;
        end
    end

    assign grant_id    = grant_id_reg;
    assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario, inline checks.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_overrun = 1'b0;
    logic        fifo_wen;
    logic [7:0]  fifo_din;
    logic [1:0]  grant_id;
    logic        busy;
    logic        overrun_err;
    logic        err_clr = 1'b0;
    logic [7:0]  dat [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    int checks = 0;
    int failures = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .N_REQ(4), .DW(8), .MAX_BURST(4), .IDLE_TIMEOUT(8)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_overrun(fifo_overrun),
        .fifo_wen(fifo_wen), .fifo_din(fifo_din),
        .grant_id(grant_id), .busy(busy),
        .overrun_err(overrun_err), .err_clr(err_clr)
    );

    always @(negedge wclk)
        if (wrst_n && fifo_wen)
            $display("write gid=%0d din=%02h t=%0t", grant_id, fifo_din, $time);

    task automatic cyc;
        @(posedge wclk);
        #1;
    endtask

    task automatic smp;
        @(negedge wclk);
    endtask

    task automatic test_reset;
        wrst_n = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(posedge wclk);
        smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (fifo_wen !== 1'b0) begin failures++; $display("FAIL rst_wen: got %b want 0", fifo_wen); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        checks++; if (fifo_din !== 8'h00) begin failures++; $display("FAIL rst_din: got %h want 00", fifo_din); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", overrun_err); end
        cyc;
        req_valid = 4'b0000;
        wrst_n = 1'b1;
        cyc;
    endtask

    task automatic test_single;
        req_valid = 4'b0001; req_last = 4'b0000; dat[0] = 8'h11;
        smp;
        checks++; if ({busy, fifo_wen} !== 2'b00) begin failures++; $display("FAIL t1_idle: got busy,wen=%b want 00", {busy, fifo_wen}); end
        cyc; smp;
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin failures++; $display("FAIL t1_grant: got busy=%b gid=%0d want 1/0", busy, grant_id); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t1_ready: got %b want 0001", req_ready); end
        checks++; if (fifo_wen !== 1'b1 || fifo_din !== 8'h11) begin failures++; $display("FAIL t1_beat1: got wen=%b din=%h want 1/11", fifo_wen, fifo_din); end
        cyc; dat[0] = 8'h22; smp;
        checks++; if (fifo_wen !== 1'b1 || fifo_din !== 8'h22) begin failures++; $display("FAIL t1_beat2: got wen=%b din=%h want 1/22", fifo_wen, fifo_din); end
        cyc; dat[0] = 8'h33; req_last = 4'b0001; smp;
        checks++; if (fifo_wen !== 1'b1 || fifo_din !== 8'h33) begin failures++; $display("FAIL t1_beat3: got wen=%b din=%h want 1/33", fifo_wen, fifo_din); end
        cyc; req_valid = 4'b0000; req_last = 4'b0000; smp;
        checks++; if ({busy, fifo_wen} !== 2'b00) begin failures++; $display("FAIL t1_release: got busy,wen=%b want 00", {busy, fifo_wen}); end
        // rr_ptr should now favour requester 1 over requester 0.
        cyc; req_valid = 4'b0011; req_last = 4'b0010; dat[1] = 8'h5A; smp;
        cyc; smp;
        checks++; if (grant_id !== 2'd1 || fifo_din !== 8'h5A) begin failures++; $display("FAIL t1_rrptr: got gid=%0d din=%h want 1/5a", grant_id, fifo_din); end
        cyc; req_valid = 4'b0000; req_last = 4'b0000; smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_rr_release: got busy=%b want 0", busy); end
        cyc;
    endtask

    task automatic test_round_robin;
        int writes, first_w, last_w, exp_g;
        bit exp_wen;
        wrst_n = 1'b0; cyc; wrst_n = 1'b1; cyc;
        for (int i = 0; i < 4; i++) dat[i] = 8'hA0 + 8'(i);
        req_valid = 4'b1111; req_last = 4'b0000;
        writes = 0; first_w = -1; last_w = -1;
        for (int c = 0; c < 25; c++) begin
            smp;
            exp_wen = (c % 5) != 0;
            exp_g = (c / 5) % 4;
            checks++; if (fifo_wen !== exp_wen) begin failures++; $display("FAIL t2_wen c=%0d: got %b want %b", c, fifo_wen, exp_wen); end
            if (exp_wen) begin
                checks++;
                if (grant_id !== 2'(exp_g) || fifo_din !== 8'hA0 + 8'(exp_g)) begin
                    failures++; $display("FAIL t2_grant c=%0d: got gid=%0d din=%h want %0d/%h", c, grant_id, fifo_din, exp_g, 8'hA0 + 8'(exp_g));
                end
            end
            if (fifo_wen === 1'b1) begin
                writes++;
                if (first_w < 0) first_w = c;
                last_w = c;
            end
            cyc;
        end
        req_valid = 4'b0000;
        checks++; if (writes !== 20) begin failures++; $display("FAIL t2_writes: got %0d want 20", writes); end
        checks++; if (last_w - first_w + 1 !== 24) begin failures++; $display("FAIL t2_span: got %0d want 24", last_w - first_w + 1); end
        smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_end: got busy=%b want 0", busy); end
        cyc;
    endtask

    task automatic test_full_backpressure;
        req_valid = 4'b0100; req_last = 4'b0000; dat[2] = 8'h31;
        smp; cyc; smp;
        checks++; if (grant_id !== 2'd2 || fifo_wen !== 1'b1 || fifo_din !== 8'h31) begin failures++; $display("FAIL t3_beat1: got gid=%0d wen=%b din=%h want 2/1/31", grant_id, fifo_wen, fifo_din); end
        cyc; dat[2] = 8'h32; smp;
        checks++; if (fifo_wen !== 1'b1 || fifo_din !== 8'h32) begin failures++; $display("FAIL t3_beat2: got wen=%b din=%h want 1/32", fifo_wen, fifo_din); end
        cyc; dat[2] = 8'h33; fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp;
            checks++; if ({busy, fifo_wen, req_ready} !== 6'b100000) begin failures++; $display("FAIL t3_stall%0d: got busy,wen,ready=%b want 100000", i, {busy, fifo_wen, req_ready}); end
            cyc;
        end
        fifo_full = 1'b0; smp;
        checks++; if (fifo_wen !== 1'b1 || fifo_din !== 8'h33 || req_ready !== 4'b0100) begin failures++; $display("FAIL t3_resume: got wen=%b din=%h ready=%b want 1/33/0100", fifo_wen, fifo_din, req_ready); end
        cyc; dat[2] = 8'h34; smp;
        checks++; if (fifo_wen !== 1'b1 || fifo_din !== 8'h34) begin failures++; $display("FAIL t3_beat4: got wen=%b din=%h want 1/34", fifo_wen, fifo_din); end
        cyc; req_valid = 4'b0000; smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t3_burst_release: got busy=%b want 0", busy); end
        cyc;
    endtask

    task automatic test_timeout;
        req_valid = 4'b0010; req_last = 4'b0000; dat[1] = 8'h41; dat[3] = 8'h77;
        smp; cyc; smp;
        checks++; if (grant_id !== 2'd1 || fifo_wen !== 1'b1 || fifo_din !== 8'h41) begin failures++; $display("FAIL t4_beat: got gid=%0d wen=%b din=%h want 1/1/41", grant_id, fifo_wen, fifo_din); end
        cyc; req_valid = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            smp;
            checks++; if ({busy, fifo_wen, req_ready} !== 6'b100010) begin failures++; $display("FAIL t4_hold%0d: got busy,wen,ready=%b want 100010", i, {busy, fifo_wen, req_ready}); end
            cyc;
        end
        req_last = 4'b1000; smp;
        checks++; if ({busy, fifo_wen} !== 2'b00) begin failures++; $display("FAIL t4_release: got busy,wen=%b want 00", {busy, fifo_wen}); end
        cyc; smp;
        checks++; if (busy !== 1'b1 || grant_id !== 2'd3 || fifo_din !== 8'h77) begin failures++; $display("FAIL t4_next: got busy=%b gid=%0d din=%h want 1/3/77", busy, grant_id, fifo_din); end
        cyc; req_valid = 4'b0000; req_last = 4'b0000; smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_end: got busy=%b want 0", busy); end
        cyc;
    endtask

    task automatic test_overrun;
        smp;
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL t5_init: got %b want 0", overrun_err); end
        cyc; fifo_overrun = 1'b1; cyc; fifo_overrun = 1'b0; smp;
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL t5_set: got %b want 1", overrun_err); end
        cyc; cyc; smp;
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL t5_sticky: got %b want 1", overrun_err); end
        cyc; err_clr = 1'b1; cyc; err_clr = 1'b0; smp;
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL t5_clr: got %b want 0", overrun_err); end
        cyc; fifo_overrun = 1'b1; err_clr = 1'b1; cyc; fifo_overrun = 1'b0; err_clr = 1'b0; smp;
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL t5_set_wins: got %b want 1", overrun_err); end
        cyc; err_clr = 1'b1; cyc; err_clr = 1'b0;
    endtask

    task automatic test_async_reset;
        req_valid = 4'b0100; req_last = 4'b0100; dat[2] = 8'h51;
        smp; cyc; smp;
        checks++; if (grant_id !== 2'd2 || fifo_din !== 8'h51) begin failures++; $display("FAIL t6_pre: got gid=%0d din=%h want 2/51", grant_id, fifo_din); end
        cyc; req_valid = 4'b1000; req_last = 4'b0000; dat[3] = 8'h61;
        smp; cyc; smp;
        checks++; if (grant_id !== 2'd3 || fifo_wen !== 1'b1 || fifo_din !== 8'h61) begin failures++; $display("FAIL t6_burst: got gid=%0d wen=%b din=%h want 3/1/61", grant_id, fifo_wen, fifo_din); end
        cyc; #2; wrst_n = 1'b0; #1;
        checks++; if ({busy, fifo_wen, req_ready, fifo_din} !== 14'd0) begin failures++; $display("FAIL t6_async: got busy=%b wen=%b ready=%b din=%h want all 0", busy, fifo_wen, req_ready, fifo_din); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL t6_gid_rst: got %0d want 0", grant_id); end
        cyc; req_valid = 4'b1001; req_last = 4'b0001; dat[0] = 8'h70; smp;
        checks++; if (fifo_wen !== 1'b0) begin failures++; $display("FAIL t6_in_rst: got wen=%b want 0", fifo_wen); end
        cyc; wrst_n = 1'b1; smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_idle: got busy=%b want 0", busy); end
        cyc; smp;
        checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_din !== 8'h70) begin failures++; $display("FAIL t6_restart: got busy=%b gid=%0d din=%h want 1/0/70", busy, grant_id, fifo_din); end
        cyc; req_valid = 4'b0000; req_last = 4'b0000; smp;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_end: got busy=%b want 0", busy); end
        cyc;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_full_backpressure;
        test_timeout;
        test_overrun;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the CDC FIFO write side between N_REQ producers.
- Lives entirely in the FIFO write clock domain and drives the FIFO's wen/din directly from the granted requester.
- Grants are burst-based: a grant is held until end-of-packet, the burst limit, or an idle timeout.
- Watches FIFO full/overrun so no beat is lost or duplicated.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width; must match the FIFO data width.
- MAX_BURST, 16, maximum beats per grant (1..255).
- IDLE_TIMEOUT, 8, consecutive cycles with granted valid=0 before the grant is revoked (1..255).

Ports:
- wclk, in, 1, write-domain clock; everything is rising-edge.
- wrst_n, in, 1, asynchronous active-low reset.
- req_valid, in, N_REQ, per-requester beat valid.
- req_last, in, N_REQ, per-requester end-of-packet flag, qualified by valid.
- req_data, in, N_REQ*DW, flattened data; requester i occupies bits [i*DW +: DW].
- req_ready, out, N_REQ, per-requester beat accept.
- fifo_full, in, 1, FIFO full flag (registered in the FIFO).
- fifo_overrun, in, 1, FIFO overrun pulse.
- fifo_wen, out, 1, FIFO write enable.
- fifo_din, out, DW, FIFO write data.
- grant_id, out, clog2(N_REQ), index of the current grantee; valid while busy.
- busy, out, 1, high in GRANT state.
- overrun_err, out, 1, sticky error flag.
- err_clr, in, 1, synchronous clear for overrun_err.

Behaviour:
- Reset (wrst_n=0, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, idle_cnt=0, overrun_err=0.
  - During reset, busy/req_ready/fifo_wen are 0 and fifo_din is 0.
  - Reset mid-burst aborts the grant with no further writes.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register grant_id, clear burst_cnt/idle_cnt, go to GRANT next cycle.
  - In IDLE, req_ready=0 and fifo_wen=0; latency from valid to first accept is one cycle.
- GRANT, with g=grant_id:
  - req_ready[g] = !fifo_full; all other ready bits are 0.
  - fifo_wen = req_valid[g] & !fifo_full, combinational.
  - fifo_din = req_data[g], muxed combinationally; 0 in IDLE.
  - A beat is accepted when req_valid[g] & req_ready[g]; each accepted beat increments burst_cnt.
- Grant release → IDLE on the next edge, with rr_ptr <= (g+1) mod N_REQ, when any of these holds:
  - an accepted beat has req_last[g]=1;
  - an accepted beat brings burst_cnt to MAX_BURST;
  - idle_cnt reaches IDLE_TIMEOUT.
- Gap between grants: there is always exactly one IDLE cycle between consecutive grants, with no write in that cycle.
- idle_cnt behaviour:
  - Increments on each GRANT cycle with req_valid[g]=0.
  - Resets to 0 on any cycle with req_valid[g]=1.
  - Does not advance while req_valid[g]=1 and fifo_full=1 (back-pressure is not idleness).
- fifo_full=1: no write; burst_cnt frozen; the grant is held. Writes resume the same cycle fifo_full returns to 0.
- Simultaneous last and burst limit on the same beat: single release, same result.
- Requester drops valid mid-burst: the grant is held until the timeout. Data and last from non-granted requesters are ignored.
- overrun_err:
  - Set on any cycle with fifo_overrun=1, and also if fifo_wen & fifo_full is ever observed (an assertion-level bug).
  - Cleared by err_clr; set wins over clear on the same cycle.
- Counter widths are 8 bits; parameters are bounded so no counter wraps.
- grant_id holds its last value in IDLE.

Test Plan:
1. Req0 only, beats 0x11,0x22,0x33 with last on 0x33, fifo_full=0 → busy rises 1 cycle after valid; fifo_wen high 3 consecutive cycles with din 11,22,33; back to IDLE; rr_ptr=1.
2. All 4 valid continuously, no last, MAX_BURST=4 → grant order 0,1,2,3,0; 4 writes per grant; one idle cycle between grants; 20 writes in 24 cycles.
3. Req2 granted, fifo_full forced high for 5 cycles after beat 2 → fifo_wen=0 and req_ready[2]=0 for those 5 cycles; burst_cnt stays 2; no timeout; beat 3 written the cycle full drops.
4. Req1 granted, then valid deasserted with IDLE_TIMEOUT=8 → release after 8 idle cycles; req3 (pending) granted 2 cycles later; no spurious wen.
5. fifo_overrun pulsed 1 cycle → overrun_err=1 and stays set; err_clr pulse clears it; overrun and err_clr on the same cycle → stays 1.
6. wrst_n low asynchronously mid-burst (between clock edges) → fifo_wen/busy/req_ready go to 0 immediately; after release, arbitration restarts from requester 0.
